uart_tx8_fifo: RTL and testbench

UART 8N1 transmitter with an internal byte FIFO. It sends results and status from the Mandelbrot core back to the host over the FTDI link, and is the transmit counterpart of the existing RX8 receiver. Upstream logic pushes bytes with a valid/ready handshake. The block serialises them LSB-first at a fixed baud rate, with no idle gap between queued frames.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx8_fifo_if.sv | 15 +
 rtl/byte_fifo.sv | 74 +++++++
 rtl/uart_tx8_fifo.sv | 156 +++++++++++++++
 tb/tb_uart_tx8_fifo.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels, frame size, divider helper and the
// transmitter FSM state encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam logic        UART_START_LVL = 1'b0;
  localparam logic        UART_STOP_LVL  = 1'b1;
  localparam logic        UART_IDLE_LVL  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Bit period in clock cycles, rounded to nearest.
  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx8_fifo_if.sv
// Byte push handshake into the UART transmitter.
//   tx_data  : byte to queue
//   tx_valid : tx_data is valid this cycle
//   tx_ready : transmitter can accept a byte this cycle
interface uart_tx8_fifo_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_valid;
  logic                      tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface

// File: rtl/byte_fifo.sv
// Synchronous FIFO with occupancy count; full/empty resolved by the count.
//   clk, rst_n : clock, async active-low reset (flushes the FIFO)
//   i_push/i_din : write request and data (ignored when full)
//   i_pop      : read request (ignored when empty)
//   o_head_c   : entry at the read pointer (combinational read of storage)
//   o_full, o_empty, o_count : registered status
module byte_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_din,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_head_c,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_count_nxt;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  // Simultaneous push and pop leave the count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage needs no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_head_c = r_mem[r_rd_ptr];
  assign o_full   = r_full;
  assign o_empty  = r_empty;
  assign o_count  = r_count;

endmodule

// File: rtl/uart_tx8_fifo.sv
// UART 8N1 transmitter fed by a byte FIFO; frames are sent back-to-back.
//   clk, rst_n : clock, async active-low reset
//   s_tx       : byte push handshake (slave side)
//   txd        : serial line, registered, idle high
//   busy       : FSM not idle or bytes still queued
//   fifo_count : queued bytes, excluding the frame in flight
module uart_tx8_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 24000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  uart_tx8_fifo_if.slave                    s_tx,
  output logic                              txd,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned DIV   = uart_div(CLK_HZ, BAUD);
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);

  if (DIV < 2) begin : g_div_chk
    $error("uart_tx8_fifo: bit period must be at least 2 clocks");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_tx8_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  uart_state_e               r_state;
  uart_state_e               w_state_nxt;
  logic [CNT_W-1:0]          r_baud_cnt;
  logic [CNT_W-1:0]          w_baud_cnt_nxt;
  logic [BIT_W-1:0]          r_bit_idx;
  logic [BIT_W-1:0]          w_bit_idx_nxt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] w_shift_nxt;
  logic                      r_txd;
  logic                      w_txd_nxt;
  logic                      r_busy;
  logic                      w_busy_nxt;
  logic                      w_pop;
  logic                      w_push;
  logic                      w_full;
  logic                      w_empty;
  logic [UART_DATA_BITS-1:0] w_head;
  logic                      w_bit_end;
  logic                      w_last_bit;

  assign w_push         = s_tx.tx_valid && !w_full;
  assign s_tx.tx_ready  = !w_full;
  assign w_bit_end      = (r_baud_cnt == CNT_W'(DIV - 1));
  assign w_last_bit     = (r_bit_idx == BIT_W'(UART_DATA_BITS - 1));

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (w_push),
    .i_din    (s_tx.tx_data),
    .i_pop    (w_pop),
    .o_head_c (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (fifo_count)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (!w_empty) w_state_nxt = ST_START;
      ST_START: if (w_bit_end) w_state_nxt = ST_DATA;
      ST_DATA:  if (w_bit_end && w_last_bit) w_state_nxt = ST_STOP;
      ST_STOP:  if (w_bit_end) w_state_nxt = w_empty ? ST_IDLE : ST_START;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath next values and FIFO pop; the line level is computed one edge
  // ahead so txd comes straight from a flop.
  always_comb begin
    w_pop          = 1'b0;
    w_baud_cnt_nxt = w_bit_end ? '0 : r_baud_cnt + CNT_W'(1);
    w_bit_idx_nxt  = r_bit_idx;
    w_shift_nxt    = r_shift;
    w_txd_nxt      = r_txd;
    unique case (r_state)
      ST_IDLE: begin
        w_baud_cnt_nxt = '0;
        w_txd_nxt      = UART_IDLE_LVL;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_txd_nxt   = UART_START_LVL;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_bit_idx_nxt = '0;
          w_txd_nxt     = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt   = r_shift >> 1;
          w_bit_idx_nxt = r_bit_idx + BIT_W'(1);
          w_txd_nxt     = w_last_bit ? UART_STOP_LVL : r_shift[1];
        end
      end
      ST_STOP: begin
        w_txd_nxt = UART_STOP_LVL;
        // Chain straight into the next start bit when more bytes wait.
        if (w_bit_end && !w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_txd_nxt   = UART_START_LVL;
        end
      end
      default: w_txd_nxt = UART_IDLE_LVL;
    endcase
    // Idle next cycle implies the FIFO was empty and nothing was popped.
    w_busy_nxt = (w_state_nxt != ST_IDLE) || !w_empty || w_push;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_txd      <= UART_IDLE_LVL;
      r_busy     <= 1'b0;
    end else begin
      r_baud_cnt <= w_baud_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_txd      <= w_txd_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign txd  = r_txd;
  assign busy = r_busy;

endmodule

// File: tb/tb_uart_tx8_fifo.sv
// Directed bench for uart_tx8_fifo: three instances share clk/rst_n.
//   dut_a : DIV=8, depth 16     dut_b : DIV=8, depth 4     dut_c : defaults
module tb_uart_tx8_fifo;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx8_fifo_if ifa ();
  uart_tx8_fifo_if ifb ();
  uart_tx8_fifo_if ifc ();

  logic       txd_a, busy_a;
  logic [4:0] cnt_a;
  logic       txd_b, busy_b;
  logic [2:0] cnt_b;
  logic       txd_c, busy_c;
  logic [4:0] cnt_c;

  uart_tx8_fifo #(.CLK_HZ(8), .BAUD(1), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_tx(ifa), .txd(txd_a), .busy(busy_a), .fifo_count(cnt_a));
  uart_tx8_fifo #(.CLK_HZ(8), .BAUD(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_tx(ifb), .txd(txd_b), .busy(busy_b), .fifo_count(cnt_b));
  uart_tx8_fifo dut_c (
    .clk(clk), .rst_n(rst_n), .s_tx(ifc), .txd(txd_c), .busy(busy_c), .fifo_count(cnt_c));

  int n_checks = 0;
  int n_fail   = 0;

  // Line level of frame bit idx (0 start, 1..8 data LSB first, 9 stop).
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ifa.tx_valid = 1'b0; ifb.tx_valid = 1'b0; ifc.tx_valid = 1'b0;
    ifa.tx_data = '0;    ifb.tx_data = '0;    ifc.tx_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    if ({txd_a, ifa.tx_ready, busy_a, cnt_a} !== {1'b1, 1'b1, 1'b0, 5'd0}) begin
      n_fail++; $display("FAIL reset_a got txd/rdy/busy/cnt=%b/%b/%b/%0d exp 1/1/0/0", txd_a, ifa.tx_ready, busy_a, cnt_a);
    end
    n_checks++;
    if ({txd_b, ifb.tx_ready, busy_b, cnt_b} !== {1'b1, 1'b1, 1'b0, 3'd0}) begin
      n_fail++; $display("FAIL reset_b got txd/rdy/busy/cnt=%b/%b/%b/%0d exp 1/1/0/0", txd_b, ifb.tx_ready, busy_b, cnt_b);
    end
    n_checks++;
    if ({txd_c, ifc.tx_ready, busy_c, cnt_c} !== {1'b1, 1'b1, 1'b0, 5'd0}) begin
      n_fail++; $display("FAIL reset_c got txd/rdy/busy/cnt=%b/%b/%b/%0d exp 1/1/0/0", txd_c, ifc.tx_ready, busy_c, cnt_c);
    end
    n_checks++;
  endtask

  // 0xA5 when idle: start falls one edge after accept, 80-cycle frame.
  task automatic test_single_frame();
    logic exp [10];
    exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    @(negedge clk);
    ifa.tx_data = 8'hA5; ifa.tx_valid = 1'b1;
    @(negedge clk);
    ifa.tx_valid = 1'b0; ifa.tx_data = 8'h00;
    if (cnt_a !== 5'd1 || txd_a !== 1'b1 || busy_a !== 1'b1) begin
      n_fail++; $display("FAIL single_accept got cnt/txd/busy=%0d/%b/%b exp 1/1/1", cnt_a, txd_a, busy_a);
    end
    n_checks++;
    for (int c = 0; c <= 80; c++) begin
      @(negedge clk);
      if (c < 80) begin
        if (txd_a !== exp[c/8]) begin
          n_fail++; $display("FAIL single_txd c=%0d got %b exp %b", c, txd_a, exp[c/8]);
        end
        n_checks++;
      end
      if (c == 0 && cnt_a !== 5'd0) begin
        n_fail++; $display("FAIL single_pop_count got %0d exp 0", cnt_a);
      end
      if (c == 0) n_checks++;
      if (c == 79 && busy_a !== 1'b1) begin
        n_fail++; $display("FAIL single_busy_end got %b exp 1", busy_a);
      end
      if (c == 79) n_checks++;
      if (c == 80) begin
        if (busy_a !== 1'b0 || txd_a !== 1'b1) begin
          n_fail++; $display("FAIL single_idle got busy/txd=%b/%b exp 0/1", busy_a, txd_a);
        end
        n_checks++;
      end
    end
  endtask

  // 0x00,0xFF,0x55 on consecutive cycles: 240 contiguous cycles of frames.
  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    bytes = '{8'h00, 8'hFF, 8'h55};
    for (int n = 0; n <= 242; n++) begin
      int c;
      if (n > 0) @(negedge clk);
      else       @(negedge clk);
      c = n - 2;
      if (n == 1 && (cnt_a !== 5'd1 || txd_a !== 1'b1)) begin
        n_fail++; $display("FAIL b2b_first_accept got cnt/txd=%0d/%b exp 1/1", cnt_a, txd_a);
      end
      if (n == 1) n_checks++;
      if (c >= 0 && c < 240) begin
        if (txd_a !== exp_bit(bytes[c/80], (c%80)/8)) begin
          n_fail++; $display("FAIL b2b_txd c=%0d got %b exp %b", c, txd_a, exp_bit(bytes[c/80], (c%80)/8));
        end
        n_checks++;
      end
      if (c == 0 || c == 1 || c == 80 || c == 160) begin
        logic [4:0] e;
        e = (c == 0) ? 5'd1 : (c == 1) ? 5'd2 : (c == 80) ? 5'd1 : 5'd0;
        if (cnt_a !== e) begin
          n_fail++; $display("FAIL b2b_count c=%0d got %0d exp %0d", c, cnt_a, e);
        end
        n_checks++;
      end
      if (c == 240) begin
        if (busy_a !== 1'b0 || txd_a !== 1'b1) begin
          n_fail++; $display("FAIL b2b_idle got busy/txd=%b/%b exp 0/1", busy_a, txd_a);
        end
        n_checks++;
      end
      if (n <= 2) begin
        ifa.tx_data = bytes[n]; ifa.tx_valid = 1'b1;
      end else begin
        ifa.tx_valid = 1'b0;
      end
    end
  endtask

  // Depth 4: six pushes, one pops, four queue, sixth dropped, five frames.
  task automatic test_fifo_full();
    logic [7:0] bytes [6];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int n = 0; n <= 402; n++) begin
      int c;
      @(negedge clk);
      c = n - 2;
      if (n == 1 && cnt_b !== 3'd1) begin
        n_fail++; $display("FAIL full_first_count got %0d exp 1", cnt_b);
      end
      if (n == 1) n_checks++;
      if (n == 5 || n == 6) begin
        if (cnt_b !== 3'd4 || ifb.tx_ready !== 1'b0) begin
          n_fail++; $display("FAIL full_state n=%0d got cnt/rdy=%0d/%b exp 4/0", n, cnt_b, ifb.tx_ready);
        end
        n_checks++;
      end
      if (c >= 0 && c < 400) begin
        if (txd_b !== exp_bit(bytes[c/80], (c%80)/8)) begin
          n_fail++; $display("FAIL full_txd c=%0d got %b exp %b", c, txd_b, exp_bit(bytes[c/80], (c%80)/8));
        end
        n_checks++;
      end
      if (c == 400) begin
        if (busy_b !== 1'b0 || txd_b !== 1'b1 || cnt_b !== 3'd0) begin
          n_fail++; $display("FAIL full_five_frames got busy/txd/cnt=%b/%b/%0d exp 0/1/0", busy_b, txd_b, cnt_b);
        end
        n_checks++;
      end
      if (n <= 5) begin
        ifb.tx_data = bytes[n]; ifb.tx_valid = 1'b1;
      end else begin
        ifb.tx_valid = 1'b0;
      end
    end
  endtask

  // Full FIFO, valid held: push lands only the edge after the STOP-end pop.
  task automatic test_full_pop_push();
    logic [7:0] bytes [6];
    bytes = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hE7, 8'hC3};
    for (int n = 0; n <= 482; n++) begin
      int c;
      @(negedge clk);
      c = n - 2;
      if (c == 79 || c == 80 || c == 81) begin
        logic [2:0] ec;
        logic       er;
        ec = (c == 80) ? 3'd3 : 3'd4;
        er = (c == 80) ? 1'b1 : 1'b0;
        if (cnt_b !== ec || ifb.tx_ready !== er) begin
          n_fail++; $display("FAIL popfull c=%0d got cnt/rdy=%0d/%b exp %0d/%b", c, cnt_b, ifb.tx_ready, ec, er);
        end
        n_checks++;
      end
      if (c >= 0 && c < 480) begin
        if (txd_b !== exp_bit(bytes[c/80], (c%80)/8)) begin
          n_fail++; $display("FAIL popfull_txd c=%0d got %b exp %b", c, txd_b, exp_bit(bytes[c/80], (c%80)/8));
        end
        n_checks++;
      end
      if (c == 480) begin
        if (busy_b !== 1'b0 || txd_b !== 1'b1 || cnt_b !== 3'd0) begin
          n_fail++; $display("FAIL popfull_six_frames got busy/txd/cnt=%b/%b/%0d exp 0/1/0", busy_b, txd_b, cnt_b);
        end
        n_checks++;
      end
      if (n <= 4) begin
        ifb.tx_data = bytes[n]; ifb.tx_valid = 1'b1;
      end else if (n <= 82) begin
        ifb.tx_data = bytes[5]; ifb.tx_valid = 1'b1;
      end else begin
        ifb.tx_valid = 1'b0;
      end
    end
  endtask

  // Reset during data bit 3 abandons the frame; 0x3C then goes out cleanly.
  task automatic test_reset_midframe();
    logic exp [10];
    exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    ifa.tx_data = 8'h00; ifa.tx_valid = 1'b1;
    @(negedge clk);
    ifa.tx_data = 8'h77;
    @(negedge clk);
    ifa.tx_valid = 1'b0;
    repeat (34) @(negedge clk);
    if (txd_a !== 1'b0 || cnt_a !== 5'd1) begin
      n_fail++; $display("FAIL midframe_before got txd/cnt=%b/%0d exp 0/1", txd_a, cnt_a);
    end
    n_checks++;
    #2 rst_n = 1'b0;
    #1;
    if (txd_a !== 1'b1 || cnt_a !== 5'd0 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL midframe_async got txd/cnt/busy=%b/%0d/%b exp 1/0/0", txd_a, cnt_a, busy_a);
    end
    n_checks++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ifa.tx_data = 8'h3C; ifa.tx_valid = 1'b1;
    @(negedge clk);
    ifa.tx_valid = 1'b0;
    if (cnt_a !== 5'd1) begin
      n_fail++; $display("FAIL midframe_accept got cnt=%0d exp 1", cnt_a);
    end
    n_checks++;
    for (int c = 0; c <= 80; c++) begin
      @(negedge clk);
      if (c < 80) begin
        if (txd_a !== exp[c/8]) begin
          n_fail++; $display("FAIL midframe_txd c=%0d got %b exp %b", c, txd_a, exp[c/8]);
        end
        n_checks++;
      end else begin
        if (busy_a !== 1'b0 || txd_a !== 1'b1) begin
          n_fail++; $display("FAIL midframe_idle got busy/txd=%b/%b exp 0/1", busy_a, txd_a);
        end
        n_checks++;
      end
    end
  endtask

  // Default clocking: 208-cycle bits, 2080-cycle frame for 0x01.
  task automatic test_default_baud();
    int len_start, len_b0, len_low, len_stop;
    @(negedge clk);
    ifc.tx_data = 8'h01; ifc.tx_valid = 1'b1;
    @(negedge clk);
    ifc.tx_valid = 1'b0;
    @(negedge clk);
    if (txd_c !== 1'b0) begin
      n_fail++; $display("FAIL default_latency got txd=%b exp 0", txd_c);
    end
    n_checks++;
    len_start = 0;
    while (txd_c === 1'b0 && len_start < 5000) begin @(negedge clk); len_start++; end
    len_b0 = 0;
    while (txd_c === 1'b1 && len_b0 < 5000) begin @(negedge clk); len_b0++; end
    len_low = 0;
    while (txd_c === 1'b0 && len_low < 5000) begin @(negedge clk); len_low++; end
    len_stop = 0;
    while (busy_c === 1'b1 && len_stop < 5000) begin @(negedge clk); len_stop++; end
    if (len_start != 208) begin
      n_fail++; $display("FAIL default_start_period got %0d exp 208", len_start);
    end
    n_checks++;
    if (len_b0 != 208) begin
      n_fail++; $display("FAIL default_bit_period got %0d exp 208", len_b0);
    end
    n_checks++;
    if (len_low != 1456) begin
      n_fail++; $display("FAIL default_zero_bits got %0d exp 1456", len_low);
    end
    n_checks++;
    if (len_start + len_b0 + len_low + len_stop != 2080 || txd_c !== 1'b1) begin
      n_fail++; $display("FAIL default_frame_len got %0d txd=%b exp 2080 txd=1",
                         len_start + len_b0 + len_low + len_stop, txd_c);
    end
    n_checks++;
  endtask

  initial begin
    ifa.tx_valid = 1'b0; ifb.tx_valid = 1'b0; ifc.tx_valid = 1'b0;
    ifa.tx_data = '0;    ifb.tx_data = '0;    ifc.tx_data = '0;
    do_reset();
    test_reset();
    test_single_frame();
    do_reset();
    test_back_to_back();
    do_reset();
    test_fifo_full();
    do_reset();
    test_full_pop_push();
    do_reset();
    test_reset_midframe();
    do_reset();
    test_default_baud();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
